// File: rtl/mc_dmem_responder.sv
// Multi-cycle data-memory responder: accepts one request, stalls the pipeline
// for LATENCY cycles, then pulses ack (and rd_valid for reads) for one cycle.
module mc_dmem_responder #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        stall,
  output logic        ack,
  output logic        rd_valid
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_idx;
  logic                r_wr;
  logic [15:0]         r_wdata;
  logic [15:0]         r_mem [2**ADDR_W];

  logic                w_accept;
  logic                w_commit;
  logic [ADDR_W-1:0]   w_idx;
  logic                w_wr;
  logic [15:0]         w_wdata;

  assign w_accept = (r_state == IDLE) && enable;

  // With LATENCY==1 the access commits on the accepting edge, so the live
  // request fields are used before their latched copies exist.
  assign w_idx   = (r_state == IDLE) ? addr[ADDR_W:1] : r_idx;
  assign w_wr    = (r_state == IDLE) ? wr             : r_wr;
  assign w_wdata = (r_state == IDLE) ? data_in        : r_wdata;

  // Gated by rst_n so a write never lands while reset is asserted.
  assign w_commit = rst_n && ((LATENCY == 1) ? w_accept
                                             : (r_state == BUSY && r_cnt == 4'd1));

  assign stall    = w_accept || (r_state == BUSY);
  assign ack      = (r_state == DONE);
  assign rd_valid = (r_state == DONE) && !r_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_idx    <= '0;
      r_wr     <= 1'b0;
      r_wdata  <= 16'h0000;
      data_out <= 16'h0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_idx   <= addr[ADDR_W:1];
            r_wr    <= wr;
            r_wdata <= data_in;
            if (LATENCY == 1) begin
              r_state <= DONE;
            end else begin
              r_state <= BUSY;
              r_cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_commit && !w_wr) data_out <= r_mem[w_idx];
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_commit && w_wr) r_mem[w_idx] <= w_wdata;
  end

endmodule

// File: tb/tb_mc_dmem_responder.sv
// Directed bench: LATENCY=4 instance for timing/data/reset cases, LATENCY=1
// instance for the streaming case.
module tb_mc_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, wr;
  logic [15:0] addr, din, dout;
  logic        stall, ack, rd_valid;
  logic        b_enable, b_wr;
  logic [15:0] b_addr, b_din, b_dout;
  logic        b_stall, b_ack, b_rd_valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mc_dmem_responder #(.LATENCY(4), .ADDR_W(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
    .data_in(din), .data_out(dout), .stall(stall), .ack(ack), .rd_valid(rd_valid)
  );

  mc_dmem_responder #(.LATENCY(1), .ADDR_W(10)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(b_enable), .wr(b_wr), .addr(b_addr),
    .data_in(b_din), .data_out(b_dout), .stall(b_stall), .ack(b_ack), .rd_valid(b_rd_valid)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One LATENCY=4 access starting in the current cycle; optionally scrambles
  // addr/data_in during the stalled cycles.
  task automatic acc(input logic w, input logic [15:0] a, input logic [15:0] d,
                     input logic [15:0] exp, input bit scr, input string tag);
    enable = 1'b1; wr = w; addr = a; din = d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({tag, "_stall"}, 16'(stall), 16'd1);
      chk({tag, "_noack"}, 16'(ack), 16'd0);
      step();
      if (scr) begin
        addr = 16'($urandom);
        din  = 16'($urandom);
      end
    end
    @(negedge clk);
    chk({tag, "_done_stall"}, 16'(stall), 16'd0);
    chk({tag, "_ack"}, 16'(ack), 16'd1);
    chk({tag, "_rdv"}, 16'(rd_valid), 16'(!w));
    if (!w) chk({tag, "_data"}, dout, exp);
    step();
    enable = 1'b0; wr = 1'b0; addr = 16'h0; din = 16'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; wr = 1'b0; addr = 16'h0; din = 16'h0;
    b_enable = 1'b0; b_wr = 1'b0; b_addr = 16'h0; b_din = 16'h0;
    #3;
    chk("rst_stall", 16'(stall), 16'd0);
    chk("rst_ack", 16'(ack), 16'd0);
    chk("rst_rdv", 16'(rd_valid), 16'd0);
    chk("rst_dout", dout, 16'h0000);
    enable = 1'b1; #1;
    chk("rst_stall_follows_en", 16'(stall), 16'd1);
    chk("rst_ack_en", 16'(ack), 16'd0);
    enable = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_stall", 16'(stall), 16'd0);
      chk("idle_ack", 16'(ack), 16'd0);
      chk("idle_rdv", 16'(rd_valid), 16'd0);
      chk("idle_dout", dout, 16'h0000);
      step();
    end

    // Write then read back after exactly one bubble cycle.
    acc(1'b1, 16'h0010, 16'hBEEF, 16'h0, 1'b0, "wr_beef");
    acc(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, "rd_beef");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("hold_dout", dout, 16'hBEEF);
      chk("hold_ack", 16'(ack), 16'd0);
      step();
    end
    acc(1'b1, 16'h0002, 16'h1234, 16'h0, 1'b0, "wr_1234");
    chk("hold_after_wr", dout, 16'hBEEF);
    acc(1'b0, 16'h0003, 16'h0000, 16'h1234, 1'b0, "rd_odd_byte");
    acc(1'b0, 16'h0802, 16'h0000, 16'h1234, 1'b0, "rd_alias");

    // Reset in the middle of a write leaves memory untouched.
    acc(1'b1, 16'h0020, 16'h5555, 16'h0, 1'b0, "wr_5555");
    enable = 1'b1; wr = 1'b1; addr = 16'h0020; din = 16'hAAAA;
    step(); step();
    rst_n = 1'b0; enable = 1'b0; #1;
    chk("midrst_ack", 16'(ack), 16'd0);
    chk("midrst_stall", 16'(stall), 16'd0);
    chk("midrst_dout", dout, 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postrst_ack", 16'(ack), 16'd0);
      chk("postrst_stall", 16'(stall), 16'd0);
      step();
    end
    acc(1'b0, 16'h0020, 16'h0000, 16'h5555, 1'b0, "rd_after_midrst");
    acc(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, "rd_mem_kept");

    // Inputs scrambled while stalled must not matter.
    acc(1'b1, 16'h0040, 16'hC0DE, 16'h0, 1'b1, "wr_scr");
    acc(1'b0, 16'h0040, 16'h0000, 16'hC0DE, 1'b1, "rd_scr");
    acc(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, "rd_noclobber");

    // LATENCY=1 streaming, enable held high, advancing on ~stall.
    begin
      logic        sw [6];
      logic [15:0] sa [6];
      logic [15:0] sd [6];
      sw = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      sa = '{16'h0000, 16'h0002, 16'h0004, 16'h0000, 16'h0002, 16'h0004};
      sd = '{16'h1111, 16'h2222, 16'h3333, 16'h1111, 16'h2222, 16'h3333};
      b_enable = 1'b1;
      for (int k = 0; k < 6; k++) begin
        b_wr = sw[k]; b_addr = sa[k]; b_din = (sw[k]) ? sd[k] : 16'hFFFF;
        @(negedge clk);
        chk("s_req_stall", 16'(b_stall), 16'd1);
        chk("s_req_ack", 16'(b_ack), 16'd0);
        step();
        @(negedge clk);
        chk("s_done_stall", 16'(b_stall), 16'd0);
        chk("s_done_ack", 16'(b_ack), 16'd1);
        chk("s_done_rdv", 16'(b_rd_valid), 16'(!sw[k]));
        if (!sw[k]) chk("s_data", b_dout, sd[k]);
        step();
      end
      b_enable = 1'b0;
      @(negedge clk);
      chk("s_end_stall", 16'(b_stall), 16'd0);
      chk("s_end_ack", 16'(b_ack), 16'd0);
      chk("s_end_hold", b_dout, 16'h3333);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mc_dmem_responder.md
Name: mc_dmem_responder

Overview:
- Multi-cycle data-memory responder. It serves the pipeline's data-memory request interface (enable/wr/addr/data_in) with a parameterised access latency.
- While an access is in flight it drives a stall back to the pipeline.
- It sits in place of the single-cycle data memory, on the far side of the MEM stage. Each request gets exactly one completion pulse.

Parameters:
- LATENCY, 4, cycles from request acceptance to completion (ack); legal range 1..15.
- ADDR_W, 10, word-address width; storage is 2**ADDR_W 16-bit words.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  request valid; held stable by the requester while stall=1.
- wr  input  1  1=write, 0=read; qualified by enable.
- addr  input  16  byte address; bit 0 ignored; word index = addr[ADDR_W:1].
- data_in  input  16  write data.
- data_out  output  16  read data; valid when rd_valid=1, held until the next read completes.
- stall  output  1  requester must freeze the pipeline and hold its request.
- ack  output  1  one-cycle completion pulse, reads and writes.
- rd_valid  output  1  one-cycle pulse; ack of a read.

Behaviour:
- States: IDLE, BUSY, DONE.
- Cycle counter width is 4 bits.
- stall is combinational: (state==IDLE & enable) | (state==BUSY).
- ack = (state==DONE); rd_valid = (state==DONE) & ~wr_q. Both come straight from registered state.
- IDLE:
  - When enable=1, latch the request at the edge: idx_q=addr[ADDR_W:1], wr_q, wdata_q.
  - If LATENCY==1, go to DONE. Otherwise go to BUSY with cnt=LATENCY-1.
  - When enable=0, stay in IDLE.
- BUSY:
  - cnt decrements each cycle.
  - When cnt==1, go to DONE at that edge.
  - enable, addr, wr and data_in are ignored. Only the latched copies are used.
- Memory update on the BUSY->DONE edge (or the IDLE->DONE edge when LATENCY==1):
  - Write: mem[idx_q] <= wdata_q.
  - Read: data_out <= mem[idx_q].
- DONE:
  - stall=0, ack=1.
  - The requester advances at the end of this cycle, so the enable seen during DONE belongs to the completing transaction and is ignored.
  - Go to IDLE unconditionally.
- Request-to-ack timing: a request first presented in cycle T has ack high in cycle T+LATENCY. stall is high in cycles T..T+LATENCY-1.
- Back-to-back requests:
  - A new request is accepted no earlier than the IDLE cycle after DONE, i.e. one bubble cycle per access.
  - In that IDLE cycle stall rises again combinationally with enable.
- Write data visibility: a read issued after a write's ack returns the written data (no hazard inside the block).
- Address wrap: addresses with addr[15:ADDR_W+1] != 0 alias onto word index addr[ADDR_W:1]. No error is reported.
- Reset (rst_n=0, asynchronous):
  - state=IDLE, cnt=0, data_out=16'h0000, and all latched request fields cleared.
  - stall follows enable (combinational); ack=0, rd_valid=0.
  - Memory contents are not reset.
- Reset mid-operation: a write that has not reached DONE is discarded (mem is unchanged). A read in flight is dropped with no ack.
- enable=0 during BUSY is a requester protocol violation. The access completes anyway, with no special handling.

Test Plan:
- Reset: rst_n=0 with enable=0 -> stall=0, ack=0, rd_valid=0, data_out=0. Then release rst_n, hold enable=0 for 5 cycles -> all outputs unchanged.
- Write-then-read, LATENCY=4:
  - Write addr=16'h0010, data=16'hBEEF at cycle T -> stall=1 in T..T+3; ack=1 and rd_valid=0 at T+4.
  - Read addr=16'h0010 at T+5 -> ack=1 and rd_valid=1 at T+9; data_out=16'hBEEF, held after T+9.
- Byte-address and wrap, ADDR_W=10:
  - Write 16'h1234 to addr 16'h0002.
  - Read addr 16'h0003 -> 16'h1234.
  - Read addr 16'h0802 -> 16'h1234 (index 1 aliased).
- Reset mid-write:
  - Write 16'hAAAA to addr 16'h0020 (prior content 16'h5555).
  - Pulse rst_n low at T+2 -> no ack; state=IDLE.
  - Subsequent read of 16'h0020 -> 16'h5555.
- LATENCY=1 streaming: enable held high with reads to addrs 0, 2, 4 in sequence, requester advancing on ~stall -> ack in every other cycle, stall pattern 1,0,1,0,..., correct data on each rd_valid.
- Input changes ignored during BUSY: change addr and data_in every cycle while stall=1 -> stored/read data match the values latched in the request cycle only.
